id_ex_stage: RTL and testbench

Parametrised successor to the decode stage.
- Keeps register-file read, immediate extension and rt/rd extraction.
- Adds write-through bypass, a mode-dependent immediate unit and load-use hazard detection.
- Adds a registered ID/EX pipeline boundary with stall and flush.
- Sits between the IF/ID register and the EX stage of the MIPS pipeline.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/id_ex_stage_register_file.sv | 51 +++++
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the ID/EX slice.
// Holds opcode values, instruction field positions and the decode helper functions.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int FIELD_W    = 5;
  localparam int OPCODE_W   = 6;

  typedef enum logic [1:0] {
    IMM_SIGN,
    IMM_ZERO,
    IMM_UPPER
  } imm_mode_e;

  // rt is a source operand only for R-type, branches and stores.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE)   || (opcode == OP_SW);
  endfunction

  function automatic imm_mode_e imm_mode(input logic [5:0] opcode);
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: return IMM_ZERO;
      OP_LUI:                   return IMM_UPPER;
      default:                  return IMM_SIGN;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_register_file.sv
// Two-read, one-write register file with entry 0 hardwired to zero.
// A write in flight is forwarded to matching reads in the same cycle.
module register_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] read_register_1,
  input  logic [REG_ADDR_WIDTH-1:0] read_register_2,
  input  logic                      reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic [DATA_WIDTH-1:0]     read_data_1,
  output logic [DATA_WIDTH-1:0]     read_data_2
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_en;

  assign write_en = reg_write && (write_register != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_register] <= write_data;
    end
  end

  // Entry 0 is forced to zero on read so it never depends on array contents.
  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (write_en && (write_register == read_register_1)) begin
      read_data_1 = write_data;
    end else if (read_register_1 != '0) begin
      read_data_1 = regs[read_register_1];
    end
    if (write_en && (write_register == read_register_2)) begin
      read_data_2 = write_data;
    end else if (read_register_2 != '0) begin
      read_data_2 = regs[read_register_2];
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with register read, immediate extension, load-use hazard detection
// and the registered ID/EX boundary feeding the EX stage.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_next_pc,
  input  logic [31:0]               i_instruction,
  input  logic                      i_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_write_register,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic                      i_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt,
  input  logic                      i_flush,
  output logic                      o_stall,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_next_pc,
  output logic [DATA_WIDTH-1:0]     o_read_data_1,
  output logic [DATA_WIDTH-1:0]     o_read_data_2,
  output logic [DATA_WIDTH-1:0]     o_extended_imm,
  output logic [REG_ADDR_WIDTH-1:0] o_rs,
  output logic [REG_ADDR_WIDTH-1:0] o_rt,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic [5:0]                o_opcode,
  output logic [5:0]                o_funct
);

  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [IMM_WIDTH-1:0]      imm;
  logic [DATA_WIDTH-1:0]     extended_imm;
  logic [DATA_WIDTH-1:0]     read_data_1;
  logic [DATA_WIDTH-1:0]     read_data_2;

  assign opcode = i_instruction[OPCODE_LSB +: OPCODE_W];
  assign funct  = i_instruction[FUNCT_LSB +: OPCODE_W];
  assign rs     = REG_ADDR_WIDTH'(i_instruction[RS_LSB +: FIELD_W]);
  assign rt     = REG_ADDR_WIDTH'(i_instruction[RT_LSB +: FIELD_W]);
  assign rd     = REG_ADDR_WIDTH'(i_instruction[RD_LSB +: FIELD_W]);
  assign imm    = i_instruction[IMM_WIDTH-1:0];

  register_file #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_register_file (
    .clk             (clk),
    .reset           (reset),
    .read_register_1 (rs),
    .read_register_2 (rt),
    .reg_write       (i_reg_write),
    .write_register  (i_write_register),
    .write_data      (i_write_data),
    .read_data_1     (read_data_1),
    .read_data_2     (read_data_2)
  );

  always_comb begin
    extended_imm = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    case (imm_mode(opcode))
      IMM_ZERO:  extended_imm = DATA_WIDTH'(imm);
      IMM_UPPER: extended_imm = DATA_WIDTH'({imm, {IMM_WIDTH{1'b0}}});
      default:   extended_imm = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endcase
  end

  // A flush squashes the dependent instruction anyway, so it never needs to stall.
  assign o_stall = i_valid && !i_flush && i_ex_mem_read && (i_ex_rt != '0) &&
                   ((i_ex_rt == rs) || (uses_rt(opcode) && (i_ex_rt == rt)));

  // Reset, flush and stall all load an all-zero bubble, which decodes as sll $0,$0,0.
  always_ff @(posedge clk) begin
    if (!reset || i_flush || o_stall) begin
      o_valid        <= 1'b0;
      o_next_pc      <= '0;
      o_read_data_1  <= '0;
      o_read_data_2  <= '0;
      o_extended_imm <= '0;
      o_rs           <= '0;
      o_rt           <= '0;
      o_rd           <= '0;
      o_opcode       <= '0;
      o_funct        <= '0;
    end else begin
      o_valid        <= i_valid;
      o_next_pc      <= i_next_pc;
      o_read_data_1  <= read_data_1;
      o_read_data_2  <= read_data_2;
      o_extended_imm <= extended_imm;
      o_rs           <= rs;
      o_rt           <= rt;
      o_rd           <= rd;
      o_opcode       <= opcode;
      o_funct        <= funct;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expected values.
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_next_pc;
  logic [31:0] i_instruction;
  logic        i_reg_write;
  logic [4:0]  i_write_register;
  logic [31:0] i_write_data;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        i_flush;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_next_pc;
  logic [31:0] o_read_data_1;
  logic [31:0] o_read_data_2;
  logic [31:0] o_extended_imm;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk              (clk),
    .reset            (reset),
    .i_valid          (i_valid),
    .i_next_pc        (i_next_pc),
    .i_instruction    (i_instruction),
    .i_reg_write      (i_reg_write),
    .i_write_register (i_write_register),
    .i_write_data     (i_write_data),
    .i_ex_mem_read    (i_ex_mem_read),
    .i_ex_rt          (i_ex_rt),
    .i_flush          (i_flush),
    .o_stall          (o_stall),
    .o_valid          (o_valid),
    .o_next_pc        (o_next_pc),
    .o_read_data_1    (o_read_data_1),
    .o_read_data_2    (o_read_data_2),
    .o_extended_imm   (o_extended_imm),
    .o_rs             (o_rs),
    .o_rt             (o_rt),
    .o_rd             (o_rd),
    .o_opcode         (o_opcode),
    .o_funct          (o_funct)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and lets combinational paths settle.
  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                               input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                               input logic mr, input logic [4:0] ert, input logic fl);
    @(negedge clk);
    i_valid          = valid;
    i_next_pc        = pc;
    i_instruction    = instr;
    i_reg_write      = rw;
    i_write_register = wr;
    i_write_data     = wd;
    i_ex_mem_read    = mr;
    i_ex_rt          = ert;
    i_flush          = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset_valid", {31'b0, o_valid}, 32'h0);
    checkOutput("reset_rd1", o_read_data_1, 32'h0);
    checkOutput("reset_pc", o_next_pc, 32'h0);
    checkOutput("reset_stall", {31'b0, o_stall}, 32'h0);

    // Register writes then add $3,$1,$2
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 32'h0000000A, 1'b0, 5'd0, 1'b0);
    reset = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 5'd2, 32'h00000014, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00000104, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("add_rd1", o_read_data_1, 32'h0000000A);
    checkOutput("add_rd2", o_read_data_2, 32'h00000014);
    checkOutput("add_rs", {27'b0, o_rs}, 32'd1);
    checkOutput("add_rt", {27'b0, o_rt}, 32'd2);
    checkOutput("add_rd", {27'b0, o_rd}, 32'd3);
    checkOutput("add_funct", {26'b0, o_funct}, 32'h20);
    checkOutput("add_valid", {31'b0, o_valid}, 32'h1);
    checkOutput("add_pc", o_next_pc, 32'h00000104);

    // Same-cycle bypass on addi $4,$1,100
    applyStimulus(1'b1, 32'h00000108, 32'h20240064, 1'b1, 5'd1, 32'h00000055, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("byp_rd1", o_read_data_1, 32'h00000055);
    checkOutput("byp_imm", o_extended_imm, 32'h00000064);
    checkOutput("byp_rt", {27'b0, o_rt}, 32'd4);
    checkOutput("byp_opcode", {26'b0, o_opcode}, 32'h08);

    // Immediate extension modes
    applyStimulus(1'b1, 32'h0000010C, 32'h2045FFCE, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("imm_sign", o_extended_imm, 32'hFFFFFFCE);
    checkOutput("imm_sign_rd1", o_read_data_1, 32'h00000014);
    applyStimulus(1'b1, 32'h00000110, 32'h3445FFCE, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("imm_zero", o_extended_imm, 32'h0000FFCE);
    applyStimulus(1'b1, 32'h00000114, 32'h3C051234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("imm_lui", o_extended_imm, 32'h12340000);

    // Register 0 ignores writes and is never bypassed: add $3,$0,$0
    applyStimulus(1'b1, 32'h00000118, 32'h00001820, 1'b1, 5'd0, 32'h0000DEAD, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("r0_rd1", o_read_data_1, 32'h0);
    checkOutput("r0_rd2", o_read_data_2, 32'h0);

    // Load-use hazard on rs
    applyStimulus(1'b1, 32'h0000011C, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    checkOutput("lu_rs_stall", {31'b0, o_stall}, 32'h1);
    tick();
    checkOutput("lu_rs_valid", {31'b0, o_valid}, 32'h0);
    checkOutput("lu_rs_rd", {27'b0, o_rd}, 32'd0);
    checkOutput("lu_rs_rd1", o_read_data_1, 32'h0);
    // Load-use hazard on rt of an R-type
    applyStimulus(1'b1, 32'h0000011C, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    checkOutput("lu_rt_stall", {31'b0, o_stall}, 32'h1);
    // addi does not read rt
    applyStimulus(1'b1, 32'h00000120, 32'h20240064, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    checkOutput("lu_addi_stall", {31'b0, o_stall}, 32'h0);
    tick();
    checkOutput("lu_addi_valid", {31'b0, o_valid}, 32'h1);
    // Store reads rt: sw $2,0($5) = 0xACA20000
    applyStimulus(1'b1, 32'h00000124, 32'hACA20000, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    checkOutput("lu_sw_stall", {31'b0, o_stall}, 32'h1);
    // No stall when slot is empty
    applyStimulus(1'b0, 32'h00000124, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    checkOutput("lu_invalid_stall", {31'b0, o_stall}, 32'h0);
    // Load targeting $0 never stalls
    applyStimulus(1'b1, 32'h00000124, 32'h00001820, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    checkOutput("lu_r0_stall", {31'b0, o_stall}, 32'h0);

    // Flush overrides the stall
    applyStimulus(1'b1, 32'h00000128, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1);
    checkOutput("flush_stall", {31'b0, o_stall}, 32'h0);
    tick();
    checkOutput("flush_valid", {31'b0, o_valid}, 32'h0);
    checkOutput("flush_rd2", o_read_data_2, 32'h0);
    checkOutput("flush_pc", o_next_pc, 32'h0);

    // Mid-run reset during a valid stream
    applyStimulus(1'b1, 32'h0000012C, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("pre_rst_valid", {31'b0, o_valid}, 32'h1);
    applyStimulus(1'b1, 32'h00000130, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("rst_valid", {31'b0, o_valid}, 32'h0);
    checkOutput("rst_rd1", o_read_data_1, 32'h0);
    checkOutput("rst_funct", {26'b0, o_funct}, 32'h0);
    checkOutput("rst_rs", {27'b0, o_rs}, 32'd0);
    applyStimulus(1'b1, 32'h00000134, 32'h00221820, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("post_rst_rd1", o_read_data_1, 32'h0);
    checkOutput("post_rst_rd2", o_read_data_2, 32'h0);
    checkOutput("post_rst_valid", {31'b0, o_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
